// File: rtl/dircc_processing_mem_reader.sv
// Avalon-MM read master for the 16-bit processing-memory port, streaming halfwords out on Avalon-ST.
// Optional running checksum of streamed beats: define DIRCC_MEMRD_CHECKSUM_EN.
module dircc_processing_mem_reader #(
    parameter int ADDR_W     = 15,
    parameter int MEM_WORDS  = 20480,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [1:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [15:0]       mem_readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       checksum
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = ADDR_W + LEN_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              first_pending;
    logic              inflight;
    logic              inflight_sop;
    logic              inflight_eop;
    logic              done_r;
    logic              err_r;

    logic [17:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [17:0]       fifo_head;

    logic              accept;
    logic              cmd_over;
    logic [SUM_W-1:0]  cmd_end;
    logic [CNT_W:0]    occupied;
    logic              issue;
    logic              pop;
    logic              drain_done;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_end   = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    assign cmd_over  = cmd_end > SUM_W'(MEM_WORDS);

    // A read only goes out if its data is guaranteed a FIFO slot on capture.
    assign occupied  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign issue     = (state == S_ISSUE) && (occupied < DEPTH_C);

    assign mem_address    = cur_addr;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 2'b11;
    assign mem_clken      = 1'b1;

    assign fifo_head = fifo_mem[rd_ptr];
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_head[15:0] : 16'h0000;
    assign out_sop   = out_valid && fifo_head[17];
    assign out_eop   = out_valid && fifo_head[16];
    assign pop       = out_valid && out_ready;

    // Look ahead at the EOP pop so done lands the cycle right after the last beat.
    assign drain_done = !inflight &&
                        ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

    assign busy = (state != S_IDLE);
    assign done = done_r;
    assign err  = err_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            first_pending <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (cmd_over) begin
                            err_r <= 1'b1;
                        end else if (cmd_len == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            cur_addr      <= cmd_addr;
                            remaining     <= cmd_len;
                            first_pending <= 1'b1;
                            state         <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        cur_addr      <= cur_addr + ADDR_W'(1);
                        remaining     <= remaining - LEN_W'(1);
                        first_pending <= 1'b0;
                        if (remaining == LEN_W'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state  <= S_FIN;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // SOP/EOP tags ride alongside the read so they reach the FIFO with their data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight     <= 1'b0;
            inflight_sop <= 1'b0;
            inflight_eop <= 1'b0;
        end else begin
            inflight     <= issue;
            inflight_sop <= first_pending;
            inflight_eop <= (remaining == LEN_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (inflight) begin
            fifo_mem[wr_ptr] <= {inflight_sop, inflight_eop, mem_readdata};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (inflight) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({inflight, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef DIRCC_MEMRD_CHECKSUM_EN
    logic [15:0] checksum_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_r <= '0;
        end else if (accept && !cmd_over) begin
            checksum_r <= '0;
        end else if (pop) begin
            checksum_r <= checksum_r + out_data;
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_dircc_processing_mem_reader.sv
// Self-checking bench for dircc_processing_mem_reader: command table, scoreboard of expected beats,
// plus back-to-back and mid-command reset sequences.
module tb_dircc_processing_mem_reader;

    localparam int MEM_WORDS   = 20480;
    localparam int FIFO_DEPTH  = 4;
    localparam int KIND_NORMAL = 0;
    localparam int KIND_ZERO   = 1;
    localparam int KIND_ERR    = 2;
    localparam int NUM_VECS    = 12;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [14:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [14:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [1:0]  mem_byteenable;
    logic        mem_clken;
    logic [15:0] mem_readdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] checksum;

    typedef struct {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] len;
        int          mode;
        int          kind;
    } vec_t;

    beat_t       exp_q[$];
    beat_t       got_beat;
    vec_t        vecs[NUM_VECS];
    logic [15:0] mem [MEM_WORDS];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;
    int ready_limit = 0;
    int popped_total = 0;
    int done_count = 0;
    int err_count = 0;
    int cs_count = 0;
    int done_cyc = -1;
    int err_cyc = -1;
    int eop_cyc = -1;
    int first_valid_cyc = -1;
    int acc_cyc = 0;
    int d0 = 0;
    int e0 = 0;
    int cs0 = 0;
    int occ = 0;
    int busy_seen = 0;
    int valid_seen = 0;
    logic [15:0] model_ck = 16'h0000;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_beat = '0;

    dircc_processing_mem_reader dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .checksum       (checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Synchronous memory: data for a read issued this cycle appears on the next.
    always @(posedge clk) begin
        if (mem_chipselect) begin
            mem_readdata <= (int'(mem_address) < MEM_WORDS) ? mem[mem_address] : 16'hDEAD;
        end
    end

    // Sink backpressure: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = ready until a beat limit.
    initial begin
        int phase;
        phase = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((phase % 3) == 0);
                default: out_ready = (popped_total < ready_limit);
            endcase
            phase++;
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int expected_checksum();
`ifdef DIRCC_MEMRD_CHECKSUM_EN
        return int'(model_ck);
`else
        return 0;
`endif
    endfunction

    // Output monitor: scoreboard compare, stall stability and issue-credit checks.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                occ = 0;
                continue;
            end
            if (mem_chipselect) begin
                cs_count++;
                check_output("credit_at_issue", int'(occ < FIFO_DEPTH), 1);
            end
            if (prev_stall) begin
                check_output("stall_hold", int'({out_valid, out_sop, out_eop, out_data}),
                             int'({1'b1, prev_beat}));
            end
            if (busy) busy_seen = 1;
            if (out_valid) begin
                valid_seen = 1;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (err) begin
                err_count++;
                err_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                popped_total++;
                check_output("beat_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    got_beat = exp_q.pop_front();
                    check_output("beat_data", int'(out_data), int'(got_beat.data));
                    check_output("beat_sop_eop", int'({out_sop, out_eop}),
                                 int'({got_beat.sop, got_beat.eop}));
                end
                if (out_eop) eop_cyc = cyc;
            end
            occ = occ + int'(mem_chipselect) - int'(out_valid && out_ready);
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_sop, out_eop, out_data};
        end
    end

    // Hold the command until accepted, then load the scoreboard with the beats it should produce.
    task automatic apply_stimulus(input logic [14:0] a, input logic [15:0] l, input int kind);
        int guard;
        guard = 0;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 1000) begin
            tick();
            guard++;
        end
        check_output("cmd_accept_timeout", int'(cmd_ready), 1);
        acc_cyc = cyc;
        d0 = done_count;
        e0 = err_count;
        cs0 = cs_count;
        busy_seen = 0;
        valid_seen = 0;
        first_valid_cyc = -1;
        eop_cyc = -1;
        if (kind != KIND_ERR) begin
            model_ck = 16'h0000;
        end
        if (kind == KIND_NORMAL) begin
            for (int i = 0; i < int'(l); i++) begin
                beat_t b;
                b.data = mem[int'(a) + i];
                b.sop  = (i == 0);
                b.eop  = (i == int'(l) - 1);
                exp_q.push_back(b);
                model_ck = model_ck + b.data;
            end
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_complete(input int kind, input int mode);
        int guard;
        guard = 0;
        if (kind == KIND_NORMAL) begin
            while (done_count == d0 && guard < 2000) begin
                tick();
                guard++;
            end
            check_output("done_seen", done_count - d0, 1);
            check_output("done_after_eop", done_cyc - eop_cyc, 1);
            check_output("beats_left", exp_q.size(), 0);
            check_output("busy_seen", busy_seen, 1);
            check_output("busy_after_fin", int'(busy), 0);
            if (mode == 0) begin
                check_output("first_latency", first_valid_cyc - acc_cyc, 3);
            end
            check_output("checksum", int'(checksum), expected_checksum());
        end else begin
            repeat (4) tick();
            if (kind == KIND_ERR) begin
                check_output("err_pulse", err_count - e0, 1);
                check_output("err_timing", err_cyc - acc_cyc, 1);
                check_output("err_no_reads", cs_count - cs0, 0);
                check_output("err_no_done", done_count - d0, 0);
            end else begin
                check_output("zero_done", done_count - d0, 1);
                check_output("zero_timing", done_cyc - acc_cyc, 1);
                check_output("zero_no_valid", valid_seen, 0);
            end
            check_output("short_no_busy", busy_seen, 0);
            check_output("short_checksum", int'(checksum), expected_checksum());
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_cmd_ready", int'(cmd_ready), 1);
        check_output("rst_chipselect", int'(mem_chipselect), 0);
        check_output("rst_mem_address", int'(mem_address), 0);
        check_output("rst_out_valid", int'(out_valid), 0);
        check_output("rst_sop_eop", int'({out_sop, out_eop}), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done_err", int'({done, err}), 0);
        check_output("rst_checksum", int'(checksum), 0);
    endtask

    initial begin
        int guard;
        int d_first;

        vecs[0]  = '{addr: 15'h0100, len: 16'd4,     mode: 0, kind: KIND_NORMAL};
        vecs[1]  = '{addr: 15'h0100, len: 16'd4,     mode: 1, kind: KIND_NORMAL};
        vecs[2]  = '{addr: 15'd20479, len: 16'd1,    mode: 0, kind: KIND_NORMAL};
        vecs[3]  = '{addr: 15'd20479, len: 16'd2,    mode: 0, kind: KIND_ERR};
        vecs[4]  = '{addr: 15'h0000, len: 16'd0,     mode: 0, kind: KIND_ZERO};
        vecs[5]  = '{addr: 15'd20480, len: 16'd0,    mode: 0, kind: KIND_ZERO};
        vecs[6]  = '{addr: 15'h0200, len: 16'd20,    mode: 1, kind: KIND_NORMAL};
        vecs[7]  = '{addr: 15'd20400, len: 16'd80,   mode: 0, kind: KIND_NORMAL};
        vecs[8]  = '{addr: 15'd20400, len: 16'd81,   mode: 0, kind: KIND_ERR};
        vecs[9]  = '{addr: 15'd32767, len: 16'hFFFF, mode: 0, kind: KIND_ERR};
        vecs[10] = '{addr: 15'h0000, len: 16'hFFFF,  mode: 0, kind: KIND_ERR};
        vecs[11] = '{addr: 15'h0040, len: 16'd7,     mode: 0, kind: KIND_NORMAL};

        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] = 16'((i * 40503 + 12345) & 32'hFFFF);
        end
        mem[16'h0100] = 16'd1;
        mem[16'h0101] = 16'd2;
        mem[16'h0102] = 16'd3;
        mem[16'h0103] = 16'd4;

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        repeat (3) tick();
        check_reset_values();
        check_output("const_write", int'(mem_write), 0);
        check_output("const_byteenable", int'(mem_byteenable), 3);
        check_output("const_clken", int'(mem_clken), 1);
        reset = 1'b0;
        tick();

        for (int v = 0; v < NUM_VECS; v++) begin
            ready_mode = vecs[v].mode;
            tick();
            apply_stimulus(vecs[v].addr, vecs[v].len, vecs[v].kind);
            wait_complete(vecs[v].kind, vecs[v].mode);
            if (v == 0) begin
                check_output("first_cmd_checksum", int'(checksum), expected_checksum());
            end
            repeat (2) tick();
        end

        // Back-to-back commands: the second must wait for the first to finish.
        ready_mode = 0;
        tick();
        apply_stimulus(15'h0010, 16'd2, KIND_NORMAL);
        d_first = d0;
        apply_stimulus(15'h0020, 16'd2, KIND_NORMAL);
        check_output("b2b_first_done", d0 - d_first, 1);
        check_output("b2b_accept_gap", acc_cyc - done_cyc, 1);
        wait_complete(KIND_NORMAL, 0);
        repeat (2) tick();

        // Reset in the middle of a stalled command.
        ready_mode = 2;
        ready_limit = popped_total + 2;
        tick();
        apply_stimulus(15'h0000, 16'd16, KIND_NORMAL);
        guard = 0;
        while (popped_total < ready_limit && guard < 200) begin
            tick();
            guard++;
        end
        check_output("beats_before_reset", popped_total - (ready_limit - 2), 2);
        repeat (3) tick();
        check_output("stalled_busy", int'(busy), 1);
        reset = 1'b1;
        exp_q.delete();
        model_ck = 16'h0000;
        #1;
        check_reset_values();
        tick();
        tick();
        reset = 1'b0;
        ready_mode = 0;
        tick();
        apply_stimulus(15'h0000, 16'd1, KIND_NORMAL);
        wait_complete(KIND_NORMAL, 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
